// File: rtl/pulse_train_generator_if.sv
// Bus bundle for pulse_train_generator; burst signals exist only when
// SQW_BURST_EN is defined.
interface pulse_train_generator_if #(
  parameter int M_W = 4
);
  logic           i_en;
  logic [M_W-1:0] i_m;
  logic [M_W-1:0] i_n;
  logic           o_w;
  logic           o_period_start;
`ifdef SQW_BURST_EN
  logic [7:0]     i_burst_len;
  logic           o_done;

  modport master (
    output i_en, i_m, i_n, i_burst_len,
    input  o_w, o_period_start, o_done
  );
  modport slave (
    input  i_en, i_m, i_n, i_burst_len,
    output o_w, o_period_start, o_done
  );
`else
  modport master (
    output i_en, i_m, i_n,
    input  o_w, o_period_start
  );
  modport slave (
    input  i_en, i_m, i_n,
    output o_w, o_period_start
  );
`endif
endinterface

// File: rtl/pulse_train_generator.sv
// Pulse-train generator: w high m*UNIT cycles, low n*UNIT cycles, updates at
// period boundaries only. Optional counted bursts under SQW_BURST_EN.
module pulse_train_generator #(
  parameter int M_W   = 4,
  parameter int UNIT  = 5,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic reset,
  pulse_train_generator_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [M_W-1:0]   r_n_s;
  logic             r_w;
  logic             r_period_start;

  logic [CNT_W-1:0] w_mTicks;
  logic [CNT_W-1:0] w_nTicks;
  logic [CNT_W-1:0] w_nsTicks;
  state_t           w_bndState;
  logic [CNT_W-1:0] w_bndCnt;
  logic             w_start;
  logic             w_runBoundary;
  logic             w_burstEnd;

  assign w_mTicks  = CNT_W'(bus.i_m) * CNT_W'(UNIT);
  assign w_nTicks  = CNT_W'(bus.i_n) * CNT_W'(UNIT);
  assign w_nsTicks = CNT_W'(r_n_s) * CNT_W'(UNIT);

  // Phase chosen at a period boundary from the live m/n inputs
  always_comb begin
    w_bndState = IDLE;
    w_bndCnt   = '0;
    if (bus.i_m != '0) begin
      w_bndState = HIGH;
      w_bndCnt   = w_mTicks - CNT_W'(1);
    end else if (bus.i_n != '0) begin
      w_bndState = LOW;
      w_bndCnt   = w_nTicks - CNT_W'(1);
    end
  end

  // A running period ends after LOW, or after HIGH when there is no low phase
  assign w_runBoundary = (r_cnt == '0) &&
                         ((r_state == LOW) || ((r_state == HIGH) && (r_n_s == '0)));

`ifdef SQW_BURST_EN
  logic [7:0] r_burst_len;
  logic [7:0] r_burst_cnt;
  logic       r_wait_low;
  logic       r_done;

  assign w_start    = bus.i_en && !r_wait_low;
  assign w_burstEnd = (r_burst_len != 8'd0) && (r_burst_cnt == r_burst_len);
  assign bus.o_done = r_done;
`else
  assign w_start    = bus.i_en;
  assign w_burstEnd = 1'b0;
`endif

  // The high count is loaded straight from m at the boundary, so only the
  // low time needs a shadow copy for the HIGH->LOW transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_n_s          <= '0;
      r_w            <= 1'b0;
      r_period_start <= 1'b0;
`ifdef SQW_BURST_EN
      r_burst_len    <= 8'd0;
      r_burst_cnt    <= 8'd0;
      r_wait_low     <= 1'b0;
      r_done         <= 1'b0;
`endif
    end else begin
      r_period_start <= 1'b0;
`ifdef SQW_BURST_EN
      r_done <= 1'b0;
      if (!bus.i_en) r_wait_low <= 1'b0;
`endif
      if (r_state == IDLE) begin
        r_w <= 1'b0;
        if (w_start) begin
          r_n_s          <= bus.i_n;
          r_state        <= w_bndState;
          r_cnt          <= w_bndCnt;
          r_w            <= (w_bndState == HIGH);
          r_period_start <= (w_bndState != IDLE);
`ifdef SQW_BURST_EN
          r_burst_len    <= bus.i_burst_len;
          r_burst_cnt    <= 8'd1;
`endif
        end
      end else if (w_runBoundary) begin
        r_n_s <= bus.i_n;
        if (w_burstEnd) begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_w     <= 1'b0;
`ifdef SQW_BURST_EN
          r_done     <= 1'b1;
          r_wait_low <= 1'b1;
`endif
        end else if (!bus.i_en) begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_w     <= 1'b0;
        end else begin
          r_state        <= w_bndState;
          r_cnt          <= w_bndCnt;
          r_w            <= (w_bndState == HIGH);
          r_period_start <= (w_bndState != IDLE);
`ifdef SQW_BURST_EN
          if (w_bndState != IDLE) r_burst_cnt <= r_burst_cnt + 8'd1;
`endif
        end
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end else begin
        r_state <= LOW;
        r_cnt   <= w_nsTicks - CNT_W'(1);
        r_w     <= 1'b0;
      end
    end
  end

  assign bus.o_w            = r_w;
  assign bus.o_period_start = r_period_start;

endmodule
